// File: rtl/store_narrow_rmw.sv
// Narrows a 32-bit register value into a word-only synchronous-read RAM.
// Word stores go straight to WRITE. Halfword and byte stores read the word, merge the new lane(s), then write it back.
module store_narrow_rmw #(
    parameter int RD_LAT     = 1,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_FIN
    } state_t;

    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_SB  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   data_q, data_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          misaligned;
    logic [1:0]    lane_in;
    logic [3:0]    byte_sel;
    logic [31:0]   merged;

    assign misaligned = (req_op == OP_RSV)
                     || ((req_op == OP_SW) && (req_addr[1:0] != 2'b00))
                     || ((req_op == OP_SH) && req_addr[0]);

    // Big-endian reverses the byte lane; for aligned halfwords bit 1 of the reversed lane is 1-h.
    assign lane_in = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_sel[gi] = ((op_q == OP_SB) && (lane_q == LANE))
                               || ((op_q == OP_SH) && (lane_q[1] == LANE[1]));
            assign merged[8*gi +: 8] = !byte_sel[gi]             ? mem_rd_data[8*gi +: 8] :
                                       ((op_q == OP_SH) && LANE[0]) ? data_q[15:8]        :
                                                                      data_q[7:0];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    data_d = req_data[15:0];
                    lane_d = lane_in;
                    addr_d = {req_addr[31:2], 2'b00};
                    cnt_d  = '0;
                    if (misaligned) begin
                        state_d = ST_FIN;
                    end else if (req_op == OP_SW) begin
                        wr_data_d = req_data;
                        state_d   = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid only in the last wait cycle; sample and merge there.
                if (cnt_q == CNT_LAST) begin
                    wr_data_d = merged;
                    state_d   = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_SW;
            data_q    <= '0;
            lane_q    <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign mem_rd_en   = (state_q == ST_READ);
    assign mem_wr_en   = (state_q == ST_WRITE);
    assign done        = (state_q == ST_WRITE) || (state_q == ST_FIN);
    assign err         = (state_q == ST_FIN);
    assign mem_addr    = addr_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench: three instances (LE lat 1, LE lat 3, BE lat 3) share the request bus.
// Each instance has its own latency-exact RAM model; the RAM returns junk outside the valid cycle.
module tb_store_narrow_rmw;

    localparam logic [31:0] RAM_WORD = 32'h1122_3344;
    localparam logic [31:0] JUNK     = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic        rdy0, rd0, wr0, busy0, done0, err0;
    logic [31:0] addr0, wd0, rdd0;
    logic        rdy1, rd1, wr1, busy1, done1, err1;
    logic [31:0] addr1, wd1, rdd1;
    logic        rdy2, rd2, wr2, busy2, done2, err2;
    logic [31:0] addr2, wd2, rdd2;

    logic        v0 = 1'b0;
    logic [2:0]  v1 = 3'b000;
    logic [2:0]  v2 = 3'b000;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_narrow_rmw #(.RD_LAT(1), .BIG_ENDIAN(1'b0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .mem_addr(addr0), .mem_rd_en(rd0),
        .mem_rd_data(rdd0), .mem_wr_en(wr0), .mem_wr_data(wd0), .busy(busy0),
        .done(done0), .err(err0)
    );
    store_narrow_rmw #(.RD_LAT(3), .BIG_ENDIAN(1'b0)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .mem_addr(addr1), .mem_rd_en(rd1),
        .mem_rd_data(rdd1), .mem_wr_en(wr1), .mem_wr_data(wd1), .busy(busy1),
        .done(done1), .err(err1)
    );
    store_narrow_rmw #(.RD_LAT(3), .BIG_ENDIAN(1'b1)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .mem_addr(addr2), .mem_rd_en(rd2),
        .mem_rd_data(rdd2), .mem_wr_en(wr2), .mem_wr_data(wd2), .busy(busy2),
        .done(done2), .err(err2)
    );

    always @(posedge clk) begin
        v0 <= rd0;
        v1 <= {v1[1:0], rd1};
        v2 <= {v2[1:0], rd2};
    end
    assign rdd0 = v0    ? RAM_WORD : JUNK;
    assign rdd1 = v1[2] ? RAM_WORD : JUNK;
    assign rdd2 = v2[2] ? RAM_WORD : JUNK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (rdy0 && rdy1 && rdy2) break;
            tick();
        end
        chk("all_idle", {31'b0, rdy0 & rdy1 & rdy2}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        tick();
        req_valid = 1'b0;
        req_data  = 32'h0;
    endtask

    task automatic err_case(input string tag, input logic [1:0] op, input logic [31:0] addr);
        issue(op, addr, 32'hFFFF_FFFF);
        chk({tag, "_done0"}, {31'b0, done0}, 32'd1);
        chk({tag, "_err0"},  {31'b0, err0},  32'd1);
        chk({tag, "_err1"},  {31'b0, err1},  32'd1);
        chk({tag, "_strobes"}, {28'b0, rd0, wr0, rd1, wr1}, 32'd0);
        tick();
        chk({tag, "_after"}, {26'b0, done0, err0, rd0, wr0, rd1, wr1}, 32'd0);
        chk({tag, "_ready"}, {31'b0, rdy0}, 32'd1);
        $display("txn %s op=%0d addr=%h -> error", tag, op, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        tick();
        tick();
        chk("rst_ready", {29'b0, rdy0, rdy1, rdy2}, 32'h7);
        chk("rst_outs0", {27'b0, busy0, rd0, wr0, done0, err0}, 32'd0);
        chk("rst_addr_wd", addr0 | wd0, 32'd0);
        $display("txn reset");
        rst = 1'b0;
        tick();

        // SW aligned
        issue(2'b00, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("sw_wr0",   {31'b0, wr0}, 32'd1);
        chk("sw_addr0", addr0, 32'h0000_0100);
        chk("sw_wd0",   wd0, 32'hDEAD_BEEF);
        chk("sw_done0", {30'b0, done0, err0}, 32'b10);
        chk("sw_rd0",   {30'b0, rd0, rdy0}, 32'd0);
        chk("sw_wd2",   wd2, 32'hDEAD_BEEF);
        tick();
        chk("sw_after", {29'b0, rdy0, wr0, done0}, 32'b100);
        $display("txn SW addr=00000100 data=deadbeef");
        wait_idle();

        // SB lane 3 with a competing request held while busy
        issue(2'b10, 32'h0000_0203, 32'h0000_00AA);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 32'h0000_0300;
        req_data  = 32'h1234_5678;
        chk("sb_rd0",   {30'b0, rd0, wr0}, 32'b10);
        chk("sb_addr0", addr0, 32'h0000_0200);
        chk("sb_busy0", {30'b0, busy0, rdy0}, 32'b10);
        tick();
        chk("sb_t2_0", {29'b0, rd0, wr0, done0}, 32'd0);
        tick();
        chk("sb_wr0",   {30'b0, wr0, done0}, 32'b11);
        chk("sb_wd0",   wd0, 32'hAA22_3344);
        chk("sb_addr0h", addr0, 32'h0000_0200);
        req_valid = 1'b0;
        chk("sb_wr1_t3", {31'b0, wr1}, 32'd0);
        tick();
        tick();
        chk("sb_wr1", {30'b0, wr1, done1}, 32'b11);
        chk("sb_wd1", wd1, 32'hAA22_3344);
        chk("sb_wd2", wd2, 32'h1122_33AA);
        $display("txn SB addr=00000203 data=000000aa");
        tick();
        chk("sb_no_second", {29'b0, busy0, wr0, done0}, 32'd0);
        wait_idle();

        // SH upper half
        issue(2'b01, 32'h0000_0202, 32'h0000_CAFE);
        chk("sh_rd1", {31'b0, rd1}, 32'd1);
        tick();
        tick();
        chk("sh_wd0", wd0, 32'hCAFE_3344);
        chk("sh_wr0_wr1", {30'b0, wr0, wr1}, 32'b10);
        tick();
        chk("sh_wr1_t4", {31'b0, wr1}, 32'd0);
        tick();
        chk("sh_wr1", {30'b0, wr1, done1}, 32'b11);
        chk("sh_wd1", wd1, 32'hCAFE_3344);
        chk("sh_wd2", wd2, 32'h1122_CAFE);
        $display("txn SH addr=00000202 data=0000cafe");
        wait_idle();

        err_case("sh_misal", 2'b01, 32'h0000_0201);
        err_case("sw_misal", 2'b00, 32'h0000_0102);
        err_case("rsv_op",   2'b11, 32'h0000_0000);
        wait_idle();

        // Reset during WAIT
        issue(2'b10, 32'h0000_0203, 32'h0000_0055);
        tick();
        chk("rmid_busy1", {31'b0, busy1}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_idle1", {28'b0, busy1, rdy1, wr1, done1}, 32'b0100);
        chk("rmid_addr1", addr1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rmid_quiet", {28'b0, wr0, done0, wr1, done1}, 32'd0);
        end
        $display("txn reset during WAIT");
        issue(2'b00, 32'h0000_0400, 32'h0BAD_F00D);
        chk("post_sw_wr1", {30'b0, wr1, done1}, 32'b11);
        chk("post_sw_wd1", wd1, 32'h0BAD_F00D);
        chk("post_sw_addr1", addr1, 32'h0000_0400);
        $display("txn SW addr=00000400 data=0badf00d");
        wait_idle();

        // Address wrap, byte lane 3 (LE) / lane 0 (BE)
        issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0055);
        chk("wrap_addr0", addr0, 32'hFFFF_FFFC);
        chk("wrap_rd0", {31'b0, rd0}, 32'd1);
        tick();
        tick();
        chk("wrap_wd0", wd0, 32'h5522_3344);
        tick();
        tick();
        chk("wrap_wr2", {31'b0, wr2}, 32'd1);
        chk("wrap_wd2", wd2, 32'h1122_3355);
        $display("txn SB addr=ffffffff data=00000055");
        wait_idle();

        // SB lane 0, SH lower half
        issue(2'b10, 32'h0000_0200, 32'h0000_00AB);
        tick();
        tick();
        chk("sb0_wd0", wd0, 32'h1122_33AB);
        $display("txn SB addr=00000200 data=000000ab");
        wait_idle();
        issue(2'b01, 32'h0000_0200, 32'h0000_BEEF);
        tick();
        tick();
        chk("shl_wd0", wd0, 32'h1122_BEEF);
        tick();
        tick();
        chk("shl_wd2", wd2, 32'hBEEF_3344);
        $display("txn SH addr=00000200 data=0000beef");
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
